// File: rtl/dag_pkg.sv
// Shared DAG constants and enumerations for the reverse (decrementing) address path.
package dag_pkg;

    localparam int DAG_AW   = 14;
    localparam int DAG_NREG = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        RSP  = 2'd3
    } dag_rev_state_t;

    typedef enum logic [1:0] {
        SEL_I = 2'd0,
        SEL_M = 2'd1,
        SEL_B = 2'd2,
        SEL_L = 2'd3
    } dag_ld_sel_t;

endpackage

// File: rtl/dag_sub15.sv
// Combinational W-bit adder with optional operand inversion; y = a + (inv ? ~b : b) + cin.
module dag_sub15
    import dag_pkg::*;
#(
    parameter int W = DAG_AW + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         inv,
    input  logic         cin,
    output logic [W-1:0] y
);

    logic [W-1:0] b_eff;

    assign b_eff = inv ? ~b : b;
    assign y     = a + b_eff + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/dag_addr_rev.sv
// Decrementing post-modify DAG address generator (IDLE -> SUB -> FIX -> RSP).
// Optional macro DAG_BITREV_EN: bit-reverse ADDR for requests on register set 0.
module dag_addr_rev
    import dag_pkg::*;
#(
    parameter int AW   = DAG_AW,
    parameter int NREG = DAG_NREG
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          LD_VLD,
    input  logic [1:0]    LD_SEL,
    input  logic [1:0]    LD_IDX,
    input  logic [AW-1:0] LD_DATA,
    input  logic          REQ_VLD,
    output logic          REQ_RDY,
    input  logic [1:0]    REQ_IDX,
    output logic          RSP_VLD,
    input  logic          RSP_RDY,
    output logic [AW-1:0] ADDR,
    output logic [AW-1:0] NEXT,
    output logic          WRAP
);

    dag_rev_state_t state_q, state_d;

    logic [1:0]    idx_q, idx_d;
    logic [AW-1:0] i_lat_q, i_lat_d;
    logic [AW-1:0] m_lat_q, m_lat_d;
    logic [AW-1:0] b_lat_q, b_lat_d;
    logic [AW-1:0] l_lat_q, l_lat_d;
    logic [AW:0]   d_q, d_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] next_q, next_d;
    logic          wrap_q, wrap_d;

    logic [AW-1:0] i_q [NREG];
    logic [AW-1:0] i_d [NREG];
    logic [AW-1:0] m_q [NREG];
    logic [AW-1:0] m_d [NREG];
    logic [AW-1:0] b_q [NREG];
    logic [AW-1:0] b_d [NREG];
    logic [AW-1:0] l_q [NREG];
    logic [AW-1:0] l_d [NREG];

    logic [AW:0]   sub_a;
    logic [AW:0]   sub_b;
    logic          sub_inv;
    logic          sub_cin;
    logic [AW:0]   sub_y;

    logic          fix_wrap;
    logic [AW-1:0] fix_next;
    logic [AW-1:0] addr_issue;

    // One adder serves both passes: I - M in SUB, D + L in FIX.
    always_comb begin
        sub_a   = {1'b0, i_lat_q};
        sub_b   = {1'b0, m_lat_q};
        sub_inv = 1'b1;
        sub_cin = 1'b1;
        if (state_q == FIX) begin
            sub_a   = d_q;
            sub_b   = {1'b0, l_lat_q};
            sub_inv = 1'b0;
            sub_cin = 1'b0;
        end
    end

    dag_sub15 #(
        .W (AW + 1)
    ) u_sub (
        .a   (sub_a),
        .b   (sub_b),
        .inv (sub_inv),
        .cin (sub_cin),
        .y   (sub_y)
    );

    // A borrow out of I - M leaves D negative, so it always compares below B.
    assign fix_wrap = (l_lat_q != '0) && ($signed(d_q) < $signed({1'b0, b_lat_q}));
    assign fix_next = fix_wrap ? sub_y[AW-1:0] : d_q[AW-1:0];

`ifdef DAG_BITREV_EN
    logic [AW-1:0] i_rev;

    for (genvar gi = 0; gi < AW; gi++) begin : g_rev
        assign i_rev[gi] = i_lat_q[AW-1-gi];
    end

    assign addr_issue = (idx_q == 2'd0) ? i_rev : i_lat_q;
`else
    assign addr_issue = i_lat_q;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        i_lat_d = i_lat_q;
        m_lat_d = m_lat_q;
        b_lat_d = b_lat_q;
        l_lat_d = l_lat_q;
        d_d     = d_q;
        addr_d  = addr_q;
        next_d  = next_q;
        wrap_d  = wrap_q;
        case (state_q)
            IDLE: begin
                if (REQ_VLD) begin
                    idx_d   = REQ_IDX;
                    i_lat_d = i_q[REQ_IDX];
                    m_lat_d = m_q[REQ_IDX];
                    b_lat_d = b_q[REQ_IDX];
                    l_lat_d = l_q[REQ_IDX];
                    state_d = SUB;
                end
            end
            SUB: begin
                d_d     = sub_y;
                state_d = FIX;
            end
            FIX: begin
                next_d  = fix_next;
                wrap_d  = fix_wrap;
                addr_d  = addr_issue;
                state_d = RSP;
            end
            RSP: begin
                if (RSP_RDY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Loads land immediately; the FIX write-back overrides a same-cycle load of that I.
    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            i_d[k] = i_q[k];
            m_d[k] = m_q[k];
            b_d[k] = b_q[k];
            l_d[k] = l_q[k];
            if (LD_VLD && (LD_IDX == 2'(k))) begin
                case (dag_ld_sel_t'(LD_SEL))
                    SEL_I:   i_d[k] = LD_DATA;
                    SEL_M:   m_d[k] = LD_DATA;
                    SEL_B:   b_d[k] = LD_DATA;
                    SEL_L:   l_d[k] = LD_DATA;
                    default: ;
                endcase
            end
            if ((state_q == FIX) && (idx_q == 2'(k))) begin
                i_d[k] = fix_next;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            i_lat_q <= '0;
            m_lat_q <= '0;
            b_lat_q <= '0;
            l_lat_q <= '0;
            d_q     <= '0;
            addr_q  <= '0;
            next_q  <= '0;
            wrap_q  <= 1'b0;
            for (int k = 0; k < NREG; k++) begin
                i_q[k] <= '0;
                m_q[k] <= '0;
                b_q[k] <= '0;
                l_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            i_lat_q <= i_lat_d;
            m_lat_q <= m_lat_d;
            b_lat_q <= b_lat_d;
            l_lat_q <= l_lat_d;
            d_q     <= d_d;
            addr_q  <= addr_d;
            next_q  <= next_d;
            wrap_q  <= wrap_d;
            for (int k = 0; k < NREG; k++) begin
                i_q[k] <= i_d[k];
                m_q[k] <= m_d[k];
                b_q[k] <= b_d[k];
                l_q[k] <= l_d[k];
            end
        end
    end

    assign REQ_RDY = (state_q == IDLE);
    assign RSP_VLD = (state_q == RSP);
    assign ADDR    = addr_q;
    assign NEXT    = next_q;
    assign WRAP    = wrap_q;

endmodule
